// File: rtl/rb_seq_pkg.sv
// Shared types and widths for the register-bank instruction sequencer.
package rb_seq_pkg;

  localparam int unsigned REG_IDX_W       = 4;
  localparam int unsigned OP_W            = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

endpackage

// File: rtl/rb_seq_if.sv
// Instruction issue handshake between an issuer (master) and the sequencer (slave).
interface rb_seq_if;
  import rb_seq_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [REG_IDX_W-1:0] instr_src1;
  logic [REG_IDX_W-1:0] instr_src2;
  logic [REG_IDX_W-1:0] instr_dest;
  logic [OP_W-1:0]      instr_op;
  logic                 instr_wb;

  modport master (
    output instr_valid, instr_src1, instr_src2, instr_dest, instr_op, instr_wb,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_src1, instr_src2, instr_dest, instr_op, instr_wb,
    output instr_ready
  );
endinterface

// File: rtl/rb_seq_timer.sv
// WAIT-state cycle counter: clears outside WAIT, counts while enabled, flags the last allowed cycle.
module rb_seq_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = 8'd0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  // Counter value k-1 during the k-th WAIT cycle, so this fires in cycle TIMEOUT_CYC.
  assign expire = en && (cnt_q == LAST_CNT);
endmodule

// File: rtl/rb_sequencer.sv
// Five-state register-bank/ALU instruction sequencer with WAIT timeout.
// Optional retired-instruction counter enabled by defining RB_SEQ_PERFCNT_EN.
module rb_sequencer
  import rb_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  rb_seq_if.slave              instr,
  output logic                 rb_rd1,
  output logic                 rb_rd2,
  output logic                 rb_wr,
  output logic [REG_IDX_W-1:0] rb_src1,
  output logic [REG_IDX_W-1:0] rb_src2,
  output logic [REG_IDX_W-1:0] rb_dest,
  output logic                 alu_start,
  output logic [OP_W-1:0]      alu_op,
  input  logic                 alu_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          instr_count
);
  state_e               state_q, state_d;
  logic [REG_IDX_W-1:0] src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic                 wb_q, wb_d;
  logic                 err_q, err_d;
  logic                 tmr_expire;

  rb_seq_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != ST_WAIT),
    .en     (state_q == ST_WAIT),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dest_d  = dest_q;
    op_d    = op_q;
    wb_d    = wb_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr.instr_valid) begin
          src1_d  = instr.instr_src1;
          src2_d  = instr.instr_src2;
          dest_d  = instr.instr_dest;
          op_d    = instr.instr_op;
          wb_d    = instr.instr_wb;
          state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WAIT;
      ST_WAIT: begin
        // A result arriving in the final allowed cycle still wins over the timeout.
        if (alu_done) begin
          state_d = ST_WRITE;
        end else if (tmr_expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src1_q  <= '0;
      src2_q  <= '0;
      dest_q  <= '0;
      op_q    <= '0;
      wb_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dest_q  <= dest_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  assign instr.instr_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rb_rd1    = (state_q == ST_READ);
  assign rb_rd2    = (state_q == ST_READ);
  assign alu_start = (state_q == ST_EXEC);
  assign done      = (state_q == ST_WRITE);
  assign rb_wr     = (state_q == ST_WRITE) && wb_q && (dest_q != '0);
  assign err       = err_q;
  assign rb_src1   = src1_q;
  assign rb_src2   = src2_q;
  assign rb_dest   = dest_q;
  assign alu_op    = op_q;

`ifdef RB_SEQ_PERFCNT_EN
  logic [31:0] icnt_q, icnt_d;

  always_comb begin
    icnt_d = icnt_q;
    if (state_q == ST_WRITE) icnt_d = icnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) icnt_q <= 32'd0;
    else     icnt_q <= icnt_d;
  end

  assign instr_count = icnt_q;
`else
  assign instr_count = 32'd0;
`endif
endmodule

// File: tb/tb_rb_sequencer.sv
// Directed bench for rb_sequencer: vector table for basic flows plus hand-written timeout,
// held-valid and mid-operation reset sequences.
module tb_rb_sequencer;
  import rb_seq_pkg::*;

`ifdef RB_SEQ_PERFCNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic       ready, rd1, rd2, wr, start, busy, done, err;
    logic [3:0] src1, src2, dest, op;
  } out_t;

  typedef struct {
    string      name;
    logic       valid;
    logic [3:0] s1, s2, d, op;
    logic       wb, adone;
    out_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rb_rd1, rb_rd2, rb_wr, alu_start, alu_done, busy, done, err;
  logic [3:0]  rb_src1, rb_src2, rb_dest, alu_op;
  logic [31:0] instr_count;
  int          checks = 0;
  int          errors = 0;
  vec_t        vq[$];

  rb_seq_if ifc ();

  rb_sequencer #(.TIMEOUT_CYC(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (ifc.slave),
    .rb_rd1      (rb_rd1),
    .rb_rd2      (rb_rd2),
    .rb_wr       (rb_wr),
    .rb_src1     (rb_src1),
    .rb_src2     (rb_src2),
    .rb_dest     (rb_dest),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_done    (alu_done),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic ready, rd1, rd2, wr, start, bsy, dn, er,
                              input logic [3:0] s1, s2, d, op);
    out_t o;
    o = '{ready, rd1, rd2, wr, start, bsy, dn, er, s1, s2, d, op};
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{ifc.instr_ready, rb_rd1, rb_rd2, rb_wr, alu_start, busy, done, err,
          rb_src1, rb_src2, rb_dest, alu_op};
    return o;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic add_vec(input string nm, input logic v, input logic [3:0] s1, s2, d, op,
                         input logic wb, ad, input out_t e);
    vec_t r;
    r.name = nm; r.valid = v; r.s1 = s1; r.s2 = s2; r.d = d; r.op = op;
    r.wb = wb; r.adone = ad; r.exp = e;
    vq.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, s2, d, op, input logic wb, ad);
    ifc.instr_valid = v;
    ifc.instr_src1  = s1;
    ifc.instr_src2  = s2;
    ifc.instr_dest  = d;
    ifc.instr_op    = op;
    ifc.instr_wb    = wb;
    alu_done        = ad;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive(vq[i].valid, vq[i].s1, vq[i].s2, vq[i].d, vq[i].op, vq[i].wb, vq[i].adone);
      step();
      chk(vq[i].name, sample(), vq[i].exp);
    end
  endtask

  initial begin
    int bad;

    // Basic flow src1=3 src2=5 dest=7 op=A wb=1, result in first WAIT cycle
    add_vec("a_read",  1, 3, 5, 7, 4'hA, 1, 0, mk(0,1,1,0,0,1,0,0, 3,5,7,4'hA));
    add_vec("a_exec",  0, 0, 0, 0, 0,    0, 0, mk(0,0,0,0,1,1,0,0, 3,5,7,4'hA));
    add_vec("a_wait",  0, 0, 0, 0, 0,    0, 0, mk(0,0,0,0,0,1,0,0, 3,5,7,4'hA));
    add_vec("a_write", 0, 0, 0, 0, 0,    0, 1, mk(0,0,0,1,0,1,1,0, 3,5,7,4'hA));
    add_vec("a_idle",  0, 0, 0, 0, 0,    0, 0, mk(1,0,0,0,0,0,0,0, 3,5,7,4'hA));
    // dest=0 with wb=1; alu_done high during EXEC must not skip WAIT
    add_vec("b_read",  1, 1, 2, 0, 3,    1, 0, mk(0,1,1,0,0,1,0,0, 1,2,0,3));
    add_vec("b_exec",  0, 0, 0, 0, 0,    0, 0, mk(0,0,0,0,1,1,0,0, 1,2,0,3));
    add_vec("b_wait",  0, 0, 0, 0, 0,    0, 1, mk(0,0,0,0,0,1,0,0, 1,2,0,3));
    add_vec("b_write", 0, 0, 0, 0, 0,    0, 1, mk(0,0,0,0,0,1,1,0, 1,2,0,3));
    add_vec("b_idle",  0, 0, 0, 0, 0,    0, 0, mk(1,0,0,0,0,0,0,0, 1,2,0,3));
    // wb=0 with a nonzero dest
    add_vec("c_read",  1, 4, 6, 9, 1,    0, 0, mk(0,1,1,0,0,1,0,0, 4,6,9,1));
    add_vec("c_exec",  0, 0, 0, 0, 0,    0, 0, mk(0,0,0,0,1,1,0,0, 4,6,9,1));
    add_vec("c_wait",  0, 0, 0, 0, 0,    0, 0, mk(0,0,0,0,0,1,0,0, 4,6,9,1));
    add_vec("c_write", 0, 0, 0, 0, 0,    0, 1, mk(0,0,0,0,0,1,1,0, 4,6,9,1));
    add_vec("c_idle",  0, 0, 0, 0, 0,    0, 0, mk(1,0,0,0,0,0,0,0, 4,6,9,1));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("in_reset", sample(), mk(1,0,0,0,0,0,0,0, 0,0,0,0));
    rst = 1'b0;
    step();
    chk("after_reset", sample(), mk(1,0,0,0,0,0,0,0, 0,0,0,0));
    chk32("count_reset", instr_count, 32'd0);

    run_rows(0, 4);
    chk32("count_after_a", instr_count, exp_cnt(1));
    run_rows(5, 9);
    chk32("count_after_b", instr_count, exp_cnt(2));
    run_rows(10, 14);
    chk32("count_after_c", instr_count, exp_cnt(3));

    // Timeout: 255 WAIT cycles without alu_done
    drive(1, 2, 3, 4, 5, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("t_wait1", sample(), mk(0,0,0,0,0,1,0,0, 2,3,4,5));
    bad = 0;
    for (int k = 2; k <= 255; k++) begin
      step();
      if (sample() !== mk(0,0,0,0,0,1,0,0, 2,3,4,5)) bad++;
    end
    chk32("t_wait_hold_bad_cycles", 32'(bad), 32'd0);
    step();
    chk("t_err", sample(), mk(1,0,0,0,0,0,0,1, 2,3,4,5));
    step();
    chk("t_after_err", sample(), mk(1,0,0,0,0,0,0,0, 2,3,4,5));
    chk32("count_after_timeout", instr_count, exp_cnt(3));

    // instr_valid held high: one accept per IDLE visit, fields latched only at accept
    drive(1, 1, 1, 2, 6, 1, 0);
    step();
    chk("h_read1", sample(), mk(0,1,1,0,0,1,0,0, 1,1,2,6));
    drive(1, 9, 8, 7, 2, 1, 0);
    step();
    chk("h_exec1", sample(), mk(0,0,0,0,1,1,0,0, 1,1,2,6));
    step();
    drive(1, 9, 8, 7, 2, 1, 1);
    step();
    chk("h_write1", sample(), mk(0,0,0,1,0,1,1,0, 1,1,2,6));
    drive(1, 9, 8, 7, 2, 1, 0);
    step();
    chk("h_idle", sample(), mk(1,0,0,0,0,0,0,0, 1,1,2,6));
    step();
    chk("h_read2", sample(), mk(0,1,1,0,0,1,0,0, 9,8,7,2));
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    chk("h_write2", sample(), mk(0,0,0,1,0,1,1,0, 9,8,7,2));
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk32("count_after_held", instr_count, exp_cnt(5));

    // Reset asserted in WAIT abandons the instruction
    drive(1, 3, 4, 5, 6, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("r_wait", sample(), mk(0,0,0,0,0,1,0,0, 3,4,5,6));
    #2;
    rst = 1'b1;
    alu_done = 1'b1;
    #1;
    chk("r_async", sample(), mk(1,0,0,0,0,0,0,0, 0,0,0,0));
    chk32("r_count_zero", instr_count, 32'd0);
    step();
    rst = 1'b0;
    alu_done = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (sample() !== mk(1,0,0,0,0,0,0,0, 0,0,0,0)) bad++;
    end
    chk32("r_quiet_bad_cycles", 32'(bad), 32'd0);
    chk32("r_count_after", instr_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rb_sequencer.md
RB_SEQUENCER -- requirements
Module: rb_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, max WAIT cycles before abort (1..255).
REQ-002 clk  in  1  single system clock; FSM on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 instr_valid  in  1  issuer presents instruction.
REQ-005 instr_ready  out  1  sequencer can accept; accept = valid && ready at posedge.
REQ-006 instr_src1, instr_src2, instr_dest  in  4 each  register indices.
REQ-007 instr_op  in  4  ALU function code; instr_wb  in  1  write-back requested.
REQ-008 rb_rd1, rb_rd2, rb_wr  out  1 each  register-bank read/write enables.
REQ-009 rb_src1, rb_src2, rb_dest  out  4 each  register-bank indices.
REQ-010 alu_start  out  1  one-cycle ALU launch pulse; alu_op  out  4  latched op.
REQ-011 alu_done  in  1  ALU result valid on bank write data (Z).
REQ-012 busy  out  1; done  out  1  completion pulse; err  out  1  timeout pulse.
REQ-013 instr_count  out  32  retired-instruction count (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, READ, EXEC, WAIT, WRITE; all outputs Moore, decoded from state and latched fields.
REQ-015 IDLE: instr_ready=1, busy=0; on accept latch src1/src2/dest/op/wb, go READ.
REQ-016 READ (1 cycle): rb_rd1=rb_rd2=1, rb_src1/rb_src2 = latched values; operands captured by bank on falling edge; go EXEC.
REQ-017 EXEC (1 cycle): alu_start=1, alu_op valid; go WAIT; alu_done ignored in EXEC.
REQ-018 WAIT: 8-bit counter from 0; alu_done=1 -> WRITE; counter reaching TIMEOUT_CYC without done -> err=1 for one cycle, go IDLE, no write, no count.
REQ-019 WRITE (1 cycle): rb_dest=latched dest; rb_wr=1 only if wb=1 and dest!=0; done=1; instr_count+1; go IDLE.
REQ-020 dest=0 or wb=0: WRITE still taken, done pulses, rb_wr stays 0.
REQ-021 Min latency: accept at edge N, READ N+1, EXEC N+2, WAIT N+3, done in cycle N+4 when alu_done arrives in first WAIT cycle.
REQ-022 instr_ready=0 in all non-IDLE states; instr_valid outside IDLE ignored; no back-to-back overlap.
REQ-023 rb_rd*/rb_wr/alu_start SHALL be 0 in every state other than their owning state.
REQ-024 instr_count wraps 0xFFFFFFFF -> 0.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, latched fields 0, WAIT counter 0, instr_count 0, all enables/pulses 0, instr_ready=1 after release.
REQ-026 Reset mid-operation SHALL abandon the instruction: no rb_wr, no done, no err.

Configuration
REQ-027 RB_SEQ_PERFCNT_EN defined: instr_count implemented per REQ-019/024.
REQ-028 RB_SEQ_PERFCNT_EN undefined: counter logic absent, instr_count tied to 0; all else identical.

Structure
REQ-029 Package rb_seq_pkg SHALL hold the state enum typedef, REG_IDX_W=4, OP_W=4, default TIMEOUT_CYC.
REQ-030 Sub-module rb_seq_timer SHALL implement the WAIT counter (clear, enable, expire output).

Verification
REQ-031 Reset release, valid with src1=3, src2=5, dest=7, wb=1, alu_done in first WAIT cycle -> rb_rd1/2 in cycle 1, alu_start in cycle 2, rb_wr with rb_dest=7 and done in cycle 4.
REQ-032 dest=0, wb=1 -> done pulses, rb_wr never asserts, instr_count increments by 1.
REQ-033 alu_done held 0, TIMEOUT_CYC=255 -> err one cycle after 255 WAIT cycles, no done, instr_ready=1 next cycle.
REQ-034 instr_valid held high across an instruction -> exactly one accept per IDLE visit, second instruction READ one cycle after first WRITE's following IDLE.
REQ-035 rst asserted during WAIT -> outputs 0 immediately, no rb_wr/done afterward, instr_count=0.
REQ-036 Build without RB_SEQ_PERFCNT_EN, run REQ-031 -> instr_count remains 0, all other timing unchanged.
